ahblite_gpio_gen: RTL and testbench

Parametrised AHB-Lite GPIO controller, successor to the fixed 16-bit GPIO slave on the AHB subsystem bus.
- Adds a configurable pin count and a configurable-depth input synchroniser.
- Adds per-pin interrupt modes: level or edge, polarity select, both-edge.
- Adds sticky raw/masked interrupt status with write-1-to-clear, and atomic set/clear aliases for DOUT.
- Zero-wait-state slave; drives pad-control outputs straight to the pad ring.

---
 rtl/ahblite_gpio_gen.sv | 176 +++++++++++++++++
 tb/tb_ahblite_gpio_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_gpio_gen.sv
// AHB-Lite GPIO controller: parametrised pin count and input synchroniser,
// per-pin level/edge interrupts with sticky status, DOUT set/clear aliases.
module ahblite_gpio_gen #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [5:2]       HADDR,
  input  logic             HREADY,
  input  logic             HWRITE,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic [1:0]       HRESP,
  output logic [WIDTH-1:0] IRQ,
  output logic             IRQ_ANY,
  input  logic [WIDTH-1:0] GPIODIN,
  output logic [WIDTH-1:0] GPIODOUT,
  output logic [WIDTH-1:0] GPIOPU,
  output logic [WIDTH-1:0] GPIOPD,
  output logic [WIDTH-1:0] GPIODIR
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] WARM = CNT_W'(SYNC_STAGES + 1);

  localparam logic [3:0] A_DIN   = 4'd0;
  localparam logic [3:0] A_DOUT  = 4'd1;
  localparam logic [3:0] A_PU    = 4'd2;
  localparam logic [3:0] A_PD    = 4'd3;
  localparam logic [3:0] A_DIR   = 4'd4;
  localparam logic [3:0] A_IM    = 4'd5;
  localparam logic [3:0] A_IEDGE = 4'd6;
  localparam logic [3:0] A_IPOL  = 4'd7;
  localparam logic [3:0] A_IBOTH = 4'd8;
  localparam logic [3:0] A_RIS   = 4'd9;
  localparam logic [3:0] A_MIS   = 4'd10;
  localparam logic [3:0] A_ICR   = 4'd11;
  localparam logic [3:0] A_SET   = 4'd12;
  localparam logic [3:0] A_CLR   = 4'd13;

  logic             sel_c;
  logic             sel_q;
  logic             write_q;
  logic [3:0]       addr_q;
  logic [2:0]       size_q;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] warm_q;
  logic             warm_done;

  logic [WIDTH-1:0] dout_q, pu_q, pd_q, dir_q, im_q, iedge_q, ipol_q, iboth_q, ris_q;
  logic [WIDTH-1:0] rise, fall, edge_ev, icr_clr, ris_nxt, mis;
  logic             unused_bits;

  assign sel_c     = HSEL & HREADY & HTRANS[1];
  assign wr_en     = sel_q & write_q;
  assign wdata     = HWDATA[WIDTH-1:0];
  assign din       = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WARM);
  assign unused_bits = ^{size_q, HTRANS[0], HWDATA};

  // Address phase capture; controls hold their value between transfers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
    end else begin
      sel_q <= sel_c;
      if (sel_c) begin
        write_q <= HWRITE;
        addr_q  <= HADDR;
        size_q  <= HSIZE;
      end
    end
  end

  // Input synchroniser, edge history and post-reset warm-up counter
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q[0] <= GPIODIN;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= din;
      if (!warm_done) warm_q <= warm_q + CNT_W'(1);
    end
  end

  // Edge bits are sticky until ICR; a same-cycle event beats the clear
  always_comb begin
    rise    = din & ~prev_q;
    fall    = ~din & prev_q;
    edge_ev = '0;
    icr_clr = '0;
    if (warm_done)
      edge_ev = iedge_q & ((iboth_q & (rise | fall)) |
                           (~iboth_q & ((ipol_q & rise) | (~ipol_q & fall))));
    if (wr_en && (addr_q == A_ICR)) icr_clr = wdata;
    ris_nxt = (iedge_q & (edge_ev | (ris_q & ~icr_clr))) | (~iedge_q & ~(din ^ ipol_q));
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dout_q  <= '0;
      pu_q    <= '0;
      pd_q    <= '0;
      dir_q   <= '0;
      im_q    <= '0;
      iedge_q <= '0;
      ipol_q  <= '0;
      iboth_q <= '0;
      ris_q   <= '0;
    end else begin
      ris_q <= ris_nxt;
      if (wr_en) begin
        case (addr_q)
          A_DOUT:  dout_q  <= wdata;
          A_PU:    pu_q    <= wdata;
          A_PD:    pd_q    <= wdata;
          A_DIR:   dir_q   <= wdata;
          A_IM:    im_q    <= wdata;
          A_IEDGE: iedge_q <= wdata;
          A_IPOL:  ipol_q  <= wdata;
          A_IBOTH: iboth_q <= wdata;
          A_SET:   dout_q  <= dout_q | wdata;
          A_CLR:   dout_q  <= dout_q & ~wdata;
          default: ;
        endcase
      end
    end
  end

  // Data-phase read mux driven from the captured address
  always_comb begin
    HRDATA = 32'hDEADBEEF;
    case (addr_q)
      A_DIN:   HRDATA = 32'(din);
      A_DOUT:  HRDATA = 32'(dout_q);
      A_PU:    HRDATA = 32'(pu_q);
      A_PD:    HRDATA = 32'(pd_q);
      A_DIR:   HRDATA = 32'(dir_q);
      A_IM:    HRDATA = 32'(im_q);
      A_IEDGE: HRDATA = 32'(iedge_q);
      A_IPOL:  HRDATA = 32'(ipol_q);
      A_IBOTH: HRDATA = 32'(iboth_q);
      A_RIS:   HRDATA = 32'(ris_q);
      A_MIS:   HRDATA = 32'(mis);
      A_ICR, A_SET, A_CLR: HRDATA = 32'h0;
      default: ;
    endcase
  end

  assign mis       = ris_q & im_q;
  assign IRQ       = mis & ~dir_q;
  assign IRQ_ANY   = |IRQ;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;
  assign GPIODOUT  = dout_q;
  assign GPIOPU    = pu_q;
  assign GPIOPD    = pd_q;
  assign GPIODIR   = dir_q;

endmodule

// File: tb/tb_ahblite_gpio_gen.sv
// Bench for ahblite_gpio_gen: directed feature tasks plus randomized traffic
// against a cycle-level reference model; a second 32-pin/3-stage instance.
`timescale 1ns/1ps
module tb_ahblite_gpio_gen;
  localparam int unsigned WA = 16;
  localparam int unsigned SA = 2;
  localparam int unsigned WB = 32;
  localparam int unsigned SB = 3;

  localparam logic [3:0] W_DIN = 4'd0, W_DOUT = 4'd1, W_PU = 4'd2, W_PD = 4'd3,
                         W_DIR = 4'd4, W_IM = 4'd5, W_IEDGE = 4'd6, W_IPOL = 4'd7,
                         W_IBOTH = 4'd8, W_RIS = 4'd9, W_ICR = 4'd11,
                         W_SET = 4'd12, W_CLR = 4'd13;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic hsel_a = 1'b0, hsel_b = 1'b0, HREADY = 1'b1, HWRITE = 1'b0;
  logic [3:0]  HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HWDATA = '0;

  logic [31:0] hrdata_a, hrdata_b;
  logic hreadyout_a, hreadyout_b, irq_any_a, irq_any_b;
  logic [1:0] hresp_a, hresp_b;
  logic [WA-1:0] din_a = '0, irq_a, dout_a, pu_a, pd_a, dir_a;
  logic [WB-1:0] din_b = '0, irq_b, dout_b, pu_b, pd_b, dir_b;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahblite_gpio_gen #(.WIDTH(WA), .SYNC_STAGES(SA)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_a), .HADDR(HADDR), .HREADY(HREADY),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(hrdata_a), .HREADYOUT(hreadyout_a), .HRESP(hresp_a), .IRQ(irq_a),
    .IRQ_ANY(irq_any_a), .GPIODIN(din_a), .GPIODOUT(dout_a), .GPIOPU(pu_a),
    .GPIOPD(pd_a), .GPIODIR(dir_a));

  ahblite_gpio_gen #(.WIDTH(WB), .SYNC_STAGES(SB)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_b), .HADDR(HADDR), .HREADY(HREADY),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(hrdata_b), .HREADYOUT(hreadyout_b), .HRESP(hresp_b), .IRQ(irq_b),
    .IRQ_ANY(irq_any_b), .GPIODIN(din_b), .GPIODOUT(dout_b), .GPIOPU(pu_b),
    .GPIOPD(pd_b), .GPIODIR(dir_b));

  // Reference model of instance A: word-indexed register file, pin history queue
  logic [15:0] m_reg [16];
  logic [15:0] m_ris;
  logic [15:0] hist [$];
  int          since;
  bit          m_pend, m_pwr;
  logic [3:0]  m_poff;

  initial begin : model
    logic [15:0] d, p, icr, wd;
    bit hit;
    forever begin
      @(posedge HCLK);
      if (!HRESETn) begin
        foreach (m_reg[i]) m_reg[i] = '0;
        m_ris = '0;
        hist.delete();
        repeat (SA + 1) hist.push_back('0);
        since = 0; m_pend = 0; m_pwr = 0; m_poff = '0;
      end else begin
        d = hist[SA-1];
        p = hist[SA];
        wd = HWDATA[15:0];
        icr = (m_pend && m_pwr && m_poff == W_ICR) ? wd : 16'h0;
        for (int b = 0; b < 16; b++) begin
          if (m_reg[W_IBOTH][b]) hit = (d[b] != p[b]);
          else if (m_reg[W_IPOL][b]) hit = d[b] && !p[b];
          else hit = !d[b] && p[b];
          if (!m_reg[W_IEDGE][b]) m_ris[b] = (d[b] == m_reg[W_IPOL][b]);
          else if (since >= SA + 1 && hit) m_ris[b] = 1'b1;
          else if (icr[b]) m_ris[b] = 1'b0;
        end
        if (m_pend && m_pwr) begin
          if (m_poff >= W_DOUT && m_poff <= W_IBOTH) m_reg[m_poff] = wd;
          else if (m_poff == W_SET) m_reg[W_DOUT] = m_reg[W_DOUT] | wd;
          else if (m_poff == W_CLR) m_reg[W_DOUT] = m_reg[W_DOUT] & ~wd;
        end
        hist.push_front(din_a);
        void'(hist.pop_back());
        if (since < 1000) since++;
        m_pend = hsel_a && HREADY && HTRANS[1];
        if (m_pend) begin
          m_pwr = HWRITE;
          m_poff = HADDR;
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd();
    if (m_poff == W_DIN) return {16'h0, hist[SA-1]};
    if (m_poff >= W_DOUT && m_poff <= W_IBOTH) return {16'h0, m_reg[m_poff]};
    if (m_poff == W_RIS) return {16'h0, m_ris};
    if (m_poff == 4'd10) return {16'h0, m_ris & m_reg[W_IM]};
    if (m_poff >= W_ICR && m_poff <= W_CLR) return 32'h0;
    return 32'hDEADBEEF;
  endfunction

  task automatic addr_ph(input bit tgt, input logic [3:0] w, input bit wr);
    hsel_a = !tgt; hsel_b = tgt; HADDR = w; HWRITE = wr; HTRANS = 2'b10;
  endtask

  task automatic idle();
    hsel_a = 0; hsel_b = 0; HTRANS = 2'b00; HWRITE = 0;
  endtask

  task automatic bus_wr(input bit tgt, input logic [3:0] w, input logic [31:0] d);
    @(negedge HCLK); addr_ph(tgt, w, 1'b1);
    @(negedge HCLK); idle(); HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic bus_rd(input bit tgt, input logic [3:0] w, output logic [31:0] d);
    @(negedge HCLK); addr_ph(tgt, w, 1'b0);
    @(negedge HCLK); idle(); d = tgt ? hrdata_b : hrdata_a;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    din_a = 16'hFFFF; HRESETn = 0;
    repeat (3) @(negedge HCLK);
    checks++;
    if ({dout_a, pu_a, pd_a, dir_a} !== 64'h0) begin
      errors++; $display("FAIL reset_pads: got %h expected 0", {dout_a, pu_a, pd_a, dir_a});
    end
    checks++;
    if (hrdata_a !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 0", hrdata_a); end
    checks++;
    if (hreadyout_a !== 1'b1 || hresp_a !== 2'b00) begin
      errors++; $display("FAIL reset_resp: got %b/%b expected 1/00", hreadyout_a, hresp_a);
    end
    @(negedge HCLK); HRESETn = 1;
    repeat (5) @(negedge HCLK);
    checks++;
    if (irq_a !== 16'h0 || irq_any_a !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %h/%b expected 0/0", irq_a, irq_any_a);
    end
    bus_rd(0, W_RIS, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_ris: got %h expected 0", r); end
    bus_rd(0, W_DIN, r);
    checks++;
    if (r !== 32'h0000FFFF) begin errors++; $display("FAIL reset_din: got %h expected 0000ffff", r); end
  endtask

  task automatic test_dout_b2b();
    logic [31:0] r;
    @(negedge HCLK); addr_ph(0, W_DOUT, 1);
    @(negedge HCLK); HWDATA = 32'h00F0; addr_ph(0, W_SET, 1);
    @(negedge HCLK);
    checks++;
    if (dout_a !== 16'h00F0) begin errors++; $display("FAIL b2b_dout: got %h expected 00f0", dout_a); end
    HWDATA = 32'h000F; addr_ph(0, W_CLR, 1);
    @(negedge HCLK);
    checks++;
    if (dout_a !== 16'h00FF) begin errors++; $display("FAIL b2b_set: got %h expected 00ff", dout_a); end
    HWDATA = 32'h0030; idle();
    @(negedge HCLK);
    checks++;
    if (dout_a !== 16'h00CF) begin errors++; $display("FAIL b2b_clr: got %h expected 00cf", dout_a); end
    bus_rd(0, W_DOUT, r);
    checks++;
    if (r !== 32'h000000CF) begin errors++; $display("FAIL rd_dout: got %h expected 000000cf", r); end
    bus_rd(0, W_SET, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL rd_set: got %h expected 0", r); end
  endtask

  task automatic test_edge();
    logic [31:0] r;
    din_a = 16'h0;
    repeat (4) @(negedge HCLK);
    bus_wr(0, W_IPOL, 32'h1);
    bus_wr(0, W_IEDGE, 32'h1);
    bus_wr(0, W_IM, 32'h1);
    checks++;
    if (irq_a !== 16'h0) begin errors++; $display("FAIL edge_idle: got %h expected 0", irq_a); end
    din_a[0] = 1'b1;
    repeat (2) @(negedge HCLK);
    checks++;
    if (irq_a[0] !== 1'b0) begin errors++; $display("FAIL edge_early: got %b expected 0", irq_a[0]); end
    @(negedge HCLK);
    checks++;
    if (irq_a[0] !== 1'b1 || irq_any_a !== 1'b1) begin
      errors++; $display("FAIL edge_lat3: got %b/%b expected 1/1", irq_a[0], irq_any_a);
    end
    bus_rd(0, W_RIS, r);
    checks++;
    if (r[0] !== 1'b1) begin errors++; $display("FAIL edge_ris: got %b expected 1", r[0]); end
    bus_wr(0, W_ICR, 32'h1);
    checks++;
    if (irq_a[0] !== 1'b0) begin errors++; $display("FAIL edge_icr: got %b expected 0", irq_a[0]); end
    din_a[0] = 1'b0;
    repeat (5) @(negedge HCLK);
    checks++;
    if (irq_a[0] !== 1'b0) begin errors++; $display("FAIL edge_fall: got %b expected 0", irq_a[0]); end
  endtask

  task automatic test_both_edge();
    bus_wr(0, W_IEDGE, 32'h9);
    bus_wr(0, W_IBOTH, 32'h8);
    bus_wr(0, W_IM, 32'h9);
    bus_wr(0, W_ICR, 32'h8);
    checks++;
    if (irq_a[3] !== 1'b0) begin errors++; $display("FAIL both_clr0: got %b expected 0", irq_a[3]); end
    din_a[3] = 1'b1;
    repeat (4) @(negedge HCLK);
    checks++;
    if (irq_a[3] !== 1'b1) begin errors++; $display("FAIL both_rise: got %b expected 1", irq_a[3]); end
    bus_wr(0, W_ICR, 32'h8);
    checks++;
    if (irq_a[3] !== 1'b0) begin errors++; $display("FAIL both_clr1: got %b expected 0", irq_a[3]); end
    din_a[3] = 1'b0;
    repeat (4) @(negedge HCLK);
    checks++;
    if (irq_a[3] !== 1'b1) begin errors++; $display("FAIL both_fall: got %b expected 1", irq_a[3]); end
    // ICR commits on the same edge that the new rising edge is recorded
    din_a[3] = 1'b1;
    bus_wr(0, W_ICR, 32'h8);
    checks++;
    if (irq_a[3] !== 1'b1) begin errors++; $display("FAIL set_wins: got %b expected 1", irq_a[3]); end
  endtask

  task automatic test_level();
    logic [31:0] r;
    bus_wr(0, W_IM, 32'h29);
    @(negedge HCLK);
    checks++;
    if (irq_a[5] !== 1'b1) begin errors++; $display("FAIL lvl_low: got %b expected 1", irq_a[5]); end
    bus_wr(0, W_ICR, 32'h20);
    checks++;
    if (irq_a[5] !== 1'b1) begin errors++; $display("FAIL lvl_icr: got %b expected 1", irq_a[5]); end
    din_a[5] = 1'b1;
    repeat (2) @(negedge HCLK);
    checks++;
    if (irq_a[5] !== 1'b1) begin errors++; $display("FAIL lvl_early: got %b expected 1", irq_a[5]); end
    @(negedge HCLK);
    checks++;
    if (irq_a[5] !== 1'b0) begin errors++; $display("FAIL lvl_high: got %b expected 0", irq_a[5]); end
    din_a[5] = 1'b0;
    repeat (4) @(negedge HCLK);
    bus_wr(0, W_DIR, 32'h20);
    checks++;
    if (irq_a[5] !== 1'b0 || dir_a !== 16'h0020) begin
      errors++; $display("FAIL lvl_dir: got irq %b dir %h expected 0/0020", irq_a[5], dir_a);
    end
    bus_rd(0, W_RIS, r);
    checks++;
    if (r[5] !== 1'b1) begin errors++; $display("FAIL lvl_ris: got %b expected 1", r[5]); end
  endtask

  task automatic test_random(input int n);
    logic [15:0] e_irq;
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      e_irq = m_ris & m_reg[W_IM] & ~m_reg[W_DIR];
      checks++;
      if (dout_a !== m_reg[W_DOUT]) begin
        errors++; $display("FAIL rnd_dout[%0d]: got %h expected %h", i, dout_a, m_reg[W_DOUT]);
      end
      checks++;
      if ({pu_a, pd_a, dir_a} !== {m_reg[W_PU], m_reg[W_PD], m_reg[W_DIR]}) begin
        errors++; $display("FAIL rnd_pads[%0d]: got %h expected %h", i, {pu_a, pd_a, dir_a},
                           {m_reg[W_PU], m_reg[W_PD], m_reg[W_DIR]});
      end
      checks++;
      if (irq_a !== e_irq || irq_any_a !== (|e_irq)) begin
        errors++; $display("FAIL rnd_irq[%0d]: got %h/%b expected %h/%b", i, irq_a, irq_any_a, e_irq, |e_irq);
      end
      checks++;
      if (hrdata_a !== exp_rd()) begin
        errors++; $display("FAIL rnd_hrdata[%0d]: got %h expected %h", i, hrdata_a, exp_rd());
      end
      hsel_a = 1'($urandom);
      hsel_b = 1'b0;
      HREADY = ($urandom % 8) != 0;
      HTRANS = 2'($urandom);
      HWRITE = 1'($urandom);
      HADDR  = 4'($urandom);
      HWDATA = $urandom;
      if ($urandom % 4 == 0) din_a = 16'($urandom);
    end
    @(negedge HCLK);
    idle(); HREADY = 1'b1;
    repeat (2) @(negedge HCLK);
  endtask

  task automatic test_wide();
    logic [31:0] r;
    bus_wr(1, W_IPOL, 32'h1);
    bus_wr(1, W_IEDGE, 32'h1);
    bus_wr(1, W_IM, 32'h1);
    checks++;
    if (irq_b !== 32'h0) begin errors++; $display("FAIL wide_idle: got %h expected 0", irq_b); end
    din_b[0] = 1'b1;
    repeat (3) @(negedge HCLK);
    checks++;
    if (irq_b[0] !== 1'b0) begin errors++; $display("FAIL wide_early: got %b expected 0", irq_b[0]); end
    @(negedge HCLK);
    checks++;
    if (irq_b[0] !== 1'b1 || irq_any_b !== 1'b1) begin
      errors++; $display("FAIL wide_lat4: got %b/%b expected 1/1", irq_b[0], irq_any_b);
    end
    bus_rd(1, 4'd14, r);
    checks++;
    if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL wide_unmapped: got %h expected deadbeef", r); end
    bus_wr(1, 4'd15, 32'hFFFFFFFF);
    checks++;
    if ({dout_b, pu_b, pd_b, dir_b} !== 128'h0) begin
      errors++; $display("FAIL wide_wr3c: got %h expected 0", {dout_b, pu_b, pd_b, dir_b});
    end
    bus_rd(1, W_IM, r);
    checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL wide_im: got %h expected 1", r); end
    // Reset lands on the data-phase edge of a PU write
    @(negedge HCLK); addr_ph(1, W_PU, 1'b1);
    @(negedge HCLK); HWDATA = 32'hFFFFFFFF; idle(); HRESETn = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;
    checks++;
    if (pu_b !== 32'h0 || irq_b !== 32'h0) begin
      errors++; $display("FAIL wide_rst_pu: got %h/%h expected 0/0", pu_b, irq_b);
    end
    repeat (2) @(negedge HCLK);
    bus_rd(1, W_PU, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL wide_rst_rd: got %h expected 0", r); end
    checks++;
    if (dout_a !== 16'h0) begin errors++; $display("FAIL rst_a_dout: got %h expected 0", dout_a); end
  endtask

  initial begin
    test_reset();
    test_dout_b2b();
    test_edge();
    test_both_edge();
    test_level();
    test_random(400);
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
